// File: rtl/pipeline_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stage_buffer
// Description : Generic valid/ready inter-stage register for the PoliRISC-V
//               pipeline. Carries a packed stage payload, with an optional
//               2-entry skid for full throughput with a registered ready_o,
//               synchronous flush with bubble insertion and a saturating
//               stall counter.
// Ports       : clock, reset      - rising-edge clock, sync active-high reset
//               flush_i           - drop all held entries
//               valid_i/data_i/ready_o  - upstream handshake and payload
//               valid_o/data_o/ready_i  - downstream handshake and payload
//               occupancy_o       - entries currently held (0..2)
//               stall_count_o     - saturating count of valid && !ready_i
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stage_buffer #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_VALUE   = '0,
    parameter bit                    SKID_EN     = 1'b1,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   valid_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    output logic                   ready_o,
    output logic                   valid_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    input  logic                   ready_i,
    output logic [1:0]             occupancy_o,
    output logic [COUNT_WIDTH-1:0] stall_count_o
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] c_stall_one = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] c_stall_max = '1;

    state_t                  r_state_q, w_state_d;
    logic [DATA_WIDTH-1:0]   r_main_q,  w_main_d;
    logic [DATA_WIDTH-1:0]   r_skid_q,  w_skid_d;
    logic                    r_valid_q, w_valid_d;
    logic                    r_ready_q, w_ready_d;
    logic [COUNT_WIDTH-1:0]  r_stall_q, w_stall_d;

    logic                    w_ready;
    logic                    w_push;
    logic                    w_pop;

    generate
        if (SKID_EN) begin : g_skid_ready
            // Registered ready: no combinational path from ready_i.
            assign w_ready = r_ready_q;
        end else begin : g_comb_ready
            // Single register can be refilled in the cycle it drains.
            assign w_ready = ready_i || !r_valid_q;
        end
    endgenerate

    assign w_push = valid_i && w_ready;
    assign w_pop  = r_valid_q && ready_i;

    always_comb begin
        w_state_d = r_state_q;
        w_main_d  = r_main_q;
        w_skid_d  = r_skid_q;
        w_valid_d = r_valid_q;

        if (flush_i) begin
            // Any push this cycle is discarded; a concurrent pop has
            // already been seen downstream.
            w_state_d = ST_EMPTY;
            w_main_d  = NOP_VALUE;
            w_skid_d  = NOP_VALUE;
            w_valid_d = 1'b0;
        end else begin
            case (r_state_q)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_d = ST_ONE;
                        w_main_d  = data_i;
                        w_valid_d = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_main_d = data_i;
                    end else if (w_push && SKID_EN) begin
                        w_state_d = ST_FULL;
                        w_skid_d  = data_i;
                    end else if (w_pop) begin
                        w_state_d = ST_EMPTY;
                        w_main_d  = NOP_VALUE;
                        w_valid_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    // Skid always drains through main, preserving order.
                    if (w_pop) begin
                        w_state_d = ST_ONE;
                        w_main_d  = r_skid_q;
                        w_skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    w_state_d = ST_EMPTY;
                    w_main_d  = NOP_VALUE;
                    w_skid_d  = NOP_VALUE;
                    w_valid_d = 1'b0;
                end
            endcase
        end

        w_ready_d = (w_state_d != ST_FULL);

        w_stall_d = r_stall_q;
        if (r_valid_q && !ready_i && (r_stall_q != c_stall_max)) begin
            w_stall_d = r_stall_q + c_stall_one;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= ST_EMPTY;
            r_main_q  <= NOP_VALUE;
            r_skid_q  <= NOP_VALUE;
            r_valid_q <= 1'b0;
            r_ready_q <= 1'b1;
            r_stall_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_main_q  <= w_main_d;
            r_skid_q  <= w_skid_d;
            r_valid_q <= w_valid_d;
            r_ready_q <= w_ready_d;
            r_stall_q <= w_stall_d;
        end
    end

    assign ready_o       = w_ready;
    assign valid_o       = r_valid_q;
    assign data_o        = r_main_q;
    assign occupancy_o   = r_state_q;
    assign stall_count_o = r_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stage_buffer
// Description : Self-checking bench for pipeline_stage_buffer. Three
//               instances: skid mode (64-bit), skid mode with a 4-bit stall
//               counter, and single-register mode. Instance 0 data ordering
//               is checked by a scoreboard queue and an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_buffer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance 0: SKID_EN=1, COUNT_WIDTH=16
    logic        v0 = 0, r0 = 0, f0 = 0;
    logic [63:0] d0 = '0;
    logic        rdy0, vo0;
    logic [63:0] do0;
    logic [1:0]  occ0;
    logic [15:0] st0;

    // Instance 1: SKID_EN=1, COUNT_WIDTH=4
    logic        v1 = 0;
    logic [63:0] d1 = 64'h55;
    logic        r1 = 0, f1 = 0;
    logic        rdy1, vo1;
    logic [63:0] do1;
    logic [1:0]  occ1;
    logic [3:0]  st1;

    // Instance 2: SKID_EN=0
    logic        v2 = 0, r2 = 0, f2 = 0;
    logic [63:0] d2 = '0;
    logic        rdy2, vo2;
    logic [63:0] do2;
    logic [1:0]  occ2;
    logic [15:0] st2;

    pipeline_stage_buffer #(.DATA_WIDTH(64), .SKID_EN(1'b1), .COUNT_WIDTH(16)) u_dut0 (
        .clock(clock), .reset(reset), .flush_i(f0), .valid_i(v0), .data_i(d0),
        .ready_o(rdy0), .valid_o(vo0), .data_o(do0), .ready_i(r0),
        .occupancy_o(occ0), .stall_count_o(st0));

    pipeline_stage_buffer #(.DATA_WIDTH(64), .SKID_EN(1'b1), .COUNT_WIDTH(4)) u_dut1 (
        .clock(clock), .reset(reset), .flush_i(f1), .valid_i(v1), .data_i(d1),
        .ready_o(rdy1), .valid_o(vo1), .data_o(do1), .ready_i(r1),
        .occupancy_o(occ1), .stall_count_o(st1));

    pipeline_stage_buffer #(.DATA_WIDTH(64), .SKID_EN(1'b0), .COUNT_WIDTH(16)) u_dut2 (
        .clock(clock), .reset(reset), .flush_i(f2), .valid_i(v2), .data_i(d2),
        .ready_o(rdy2), .valid_o(vo2), .data_o(do2), .ready_i(r2),
        .occupancy_o(occ2), .stall_count_o(st2));

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed downstream transfer of instance 0 must match
    // the oldest accepted payload.
    always @(negedge clock) begin
        if (reset === 1'b0 && vo0 === 1'b1 && r0 === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h expected=none", do0);
            end else begin
                check("sb_data", do0, sb.pop_front());
            end
        end
    end

    // Drive instance 0 for one cycle; record accepted payloads.
    task automatic cyc(input logic v, input logic [63:0] d, input logic r, input logic f);
        @(posedge clock);
        #1;
        v0 = v; d0 = d; r0 = r; f0 = f;
        @(negedge clock);
        if (v && rdy0 && !f) sb.push_back(d);
        if (f) begin
            #1;
            sb.delete();
        end
    endtask

    task automatic cyc2(input logic v, input logic [63:0] d, input logic r);
        @(posedge clock);
        #1;
        v2 = v; d2 = d; r2 = r;
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        v0 = 0; r0 = 0; f0 = 0; d0 = '0;
        v1 = 0;
        v2 = 0; r2 = 0; d2 = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_valid", vo0, 0);
        check("rst_data", do0, 0);
        check("rst_ready", rdy0, 1);
        check("rst_occ", occ0, 0);
        check("rst_stall", st0, 0);
        check("rst_ready_noskid", rdy2, 1);

        // Streaming at full rate
        cyc(1, 64'h10, 1, 0);
        cyc(1, 64'h11, 1, 0);
        check("stream_occ_a", occ0, 1);
        cyc(1, 64'h12, 1, 0);
        check("stream_occ_b", occ0, 1);
        cyc(0, 0, 1, 0);
        check("stream_occ_c", occ0, 1);
        cyc(0, 0, 1, 0);
        check("stream_drained", vo0, 0);
        check("stream_stall", st0, 0);

        // Backpressure into the skid
        cyc(1, 64'hA, 0, 0);
        cyc(1, 64'hB, 0, 0);
        cyc(0, 0, 0, 0);
        check("bp_occ", occ0, 2);
        check("bp_ready", rdy0, 0);
        check("bp_data", do0, 64'hA);
        check("bp_stall_a", st0, 1);
        cyc(0, 0, 0, 0);
        check("bp_hold", do0, 64'hA);
        check("bp_stall_b", st0, 2);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        check("bp_ready_back", rdy0, 1);
        check("bp_occ_one", occ0, 1);
        cyc(0, 0, 1, 0);
        check("bp_empty", vo0, 0);
        check("bp_stall_total", st0, 3);

        // Flush with the buffer full and valid_i high
        cyc(1, 64'hA, 0, 0);
        cyc(1, 64'hB, 0, 0);
        cyc(1, 64'hC, 0, 1);
        check("fl_full", occ0, 2);
        cyc(0, 0, 0, 0);
        check("fl_valid", vo0, 0);
        check("fl_data", do0, 0);
        check("fl_occ", occ0, 0);
        check("fl_ready", rdy0, 1);
        check("fl_stall_kept", st0, 5);

        // Flush colliding with an accepted push
        cyc(1, 64'hD, 0, 0);
        cyc(1, 64'hE, 0, 1);
        cyc(0, 0, 1, 0);
        check("flp_valid", vo0, 0);
        check("flp_occ", occ0, 0);

        // Flush with a concurrent pop: the popped beat still completes
        cyc(1, 64'h20, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        check("flpop_valid", vo0, 0);
        check("flpop_stall", st0, 6);

        // Reset while holding data
        cyc(1, 64'h40, 0, 0);
        cyc(0, 0, 0, 0);
        do_reset();
        check("mrst_valid", vo0, 0);
        check("mrst_occ", occ0, 0);
        check("mrst_stall", st0, 0);

        // Saturating counter on the 4-bit instance
        for (int i = 1; i <= 22; i++) begin
            @(posedge clock);
            #1;
            v1 = 1;
            @(negedge clock);
            if (i == 12) check("sat_mid", st1, 10);
        end
        check("sat_max", st1, 15);
        check("sat_data", do1, 64'h55);
        do_reset();
        check("sat_rst", st1, 0);

        // Single-register mode
        cyc2(1, 64'h30, 0);
        cyc2(1, 64'h31, 0);
        check("ns_ready_low", rdy2, 0);
        check("ns_occ", occ2, 1);
        check("ns_data_a", do2, 64'h30);
        cyc2(1, 64'h31, 1);
        check("ns_ready_comb", rdy2, 1);
        check("ns_data_b", do2, 64'h30);
        cyc2(0, 0, 1);
        check("ns_data_c", do2, 64'h31);
        check("ns_occ_c", occ2, 1);
        cyc2(0, 0, 1);
        check("ns_empty", vo2, 0);
        check("ns_occ_e", occ2, 0);

        check("sb_left", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
